pc_gen: RTL
===========

# pc_gen

Parametrised program-counter generator for the instruction-fetch stage. It holds the current fetch address and drives the instruction-ROM read enable. It selects the next address from sequential +4, branch target or jump target, and supports pipeline stall. It halts cleanly on an out-of-range or misaligned fetch. The first instruction after reset is always fetched, never skipped.

## Interface
- ADDR_W, 32: width of PC and target buses.
- IMEM_DEPTH, 1024: instruction ROM depth in 32-bit words. Requires IMEM_DEPTH*4 <= 2^ADDR_W.
- RESET_VEC, 0: byte address of the first fetch. Must be word-aligned and < IMEM_DEPTH*4.
- clk  in  1  clock; all state updates on rising edge.
- rst  in  1  reset, synchronous, active-high.
- stall  in  1  hold PC (no advance).
- branch_taken  in  1  load branch_target.
- branch_target  in  ADDR_W  branch destination (byte address).
- jump  in  1  load jump_target.
- jump_target  in  ADDR_W  jump destination (byte address).
- pc  out  ADDR_W  current fetch address; ROM address = pc[ADDR_W-1:2].
- pc_plus4  out  ADDR_W  pc + 4 (combinational, modulo 2^ADDR_W), for link/branch base.
- imem_en  out  1  ROM read enable; high only in RUN.
- halted  out  1  high in HALT.
- fault_oob  out  1  sticky; next address fell outside ROM.
- fault_align  out  1  sticky; redirect target not word-aligned (only with macro).

## Operation
- States are BOOT, RUN and HALT.
- Reset (any state) enters BOOT:
  - pc=RESET_VEC, imem_en=0, halted=0, both faults=0.
- BOOT → RUN unconditionally on the next edge. pc stays RESET_VEC, so the first RUN cycle fetches RESET_VEC.
- In RUN, next address priority: jump > branch_taken > stall > sequential (pc+4).
  - A redirect overrides stall, so a flush during stall is never lost.
  - jump and branch_taken together: jump wins.
- Range check on the selected next address n: if n >= IMEM_DEPTH*4, go to HALT.
  - pc holds its current value.
  - fault_oob=1.
- Sequential +4 from the last word (IMEM_DEPTH*4-4) is out of range and goes to HALT. PC never wraps to 0.
- In HALT, pc is frozen, imem_en=0 and halted=1, and all inputs are ignored. Only rst leaves HALT.
- Stall in RUN: pc unchanged and imem_en stays 1, so the ROM re-reads the same word.

## Timing
- pc is registered. The next address is combinational from the same-cycle inputs and is visible on pc one edge later.
- Redirect latency: jump/branch asserted in cycle t → pc=target in t+1.
- Fault latency: the out-of-range selection in cycle t → halted=1, imem_en=0 and fault set in t+1.
- pc_plus4 is combinational from pc, zero added latency.
- All outputs are registered except pc_plus4.
- Reset has priority over every event in the same cycle.

## Configuration
- PC_ALIGN_CHECK_EN defined: a redirect target with target[1:0] != 0 goes to HALT with fault_align=1. pc holds its current value.
  - The alignment check is evaluated before the range check.
  - If both fail, only fault_align is set.
- PC_ALIGN_CHECK_EN undefined: target[1:0] is forced to 00 before use, and fault_align is tied 0.

## Structure
- Shared package cpu_pkg holds:
  - the state enum pc_state_t (BOOT, RUN, HALT);
  - the constant INSTR_BYTES=4;
  - the default RESET_VEC.
- One sub-module, pc_next_sel: combinational priority mux plus range/alignment check. It outputs next_addr, oob and misalign.
- The top level holds the state register and the pc/fault registers.

## Test plan
- Reset with RESET_VEC=0:
  - cycle after rst: pc=0, imem_en=0;
  - next cycle: pc=0, imem_en=1;
  - then pc=4, 8, 12 on successive cycles.
- stall high 3 cycles at pc=0x10 → pc stays 0x10 with imem_en=1 throughout; pc=0x14 the cycle after stall drops.
- stall=1 with branch_taken=1, target 0x40 → pc=0x40 next cycle. Then jump=1 (0x80) with branch_taken=1 (0xC0) → pc=0x80.
- IMEM_DEPTH=1024, sequential run to pc=0xFFC → next cycle halted=1, fault_oob=1, pc=0xFFC, imem_en=0. Then rst → BOOT, all faults clear.
- jump_target=0x1000 with IMEM_DEPTH=1024 → HALT with fault_oob=1, pc unchanged.
- jump_target=0x22:
  - with PC_ALIGN_CHECK_EN → halted=1, fault_align=1;
  - without it → pc=0x20, running.

Source files
------------

// File: rtl/cpu_pkg.sv
// Shared fetch-stage definitions: PC sequencer states, instruction size and
// the default reset vector.
package cpu_pkg;

    typedef enum logic [1:0] {
        BOOT = 2'd0,
        RUN  = 2'd1,
        HALT = 2'd2
    } pc_state_t;

    localparam int INSTR_BYTES       = 4;
    localparam int DEFAULT_RESET_VEC = 0;

endpackage

// File: rtl/pc_next_sel.sv
// Next-PC priority mux (jump > branch > stall > +4) with ROM range and target
// alignment checks. Alignment checking is enabled by PC_ALIGN_CHECK_EN.
module pc_next_sel
    import cpu_pkg::*;
#(
    parameter int ADDR_W     = 32,
    parameter int IMEM_DEPTH = 1024
) (
    input  logic [ADDR_W-1:0] pc_i,
    input  logic              stall_i,
    input  logic              branch_taken_i,
    input  logic [ADDR_W-1:0] branch_target_i,
    input  logic              jump_i,
    input  logic [ADDR_W-1:0] jump_target_i,
    output logic [ADDR_W-1:0] next_addr_o,
    output logic              oob_o,
    output logic              misalign_o
);

`ifdef PC_ALIGN_CHECK_EN
    localparam bit ALIGN_CHECK = 1'b1;
`else
    localparam bit ALIGN_CHECK = 1'b0;
`endif

    // One extra bit so pc+4 from the top of a full address space reads as
    // out of range instead of wrapping to 0.
    localparam logic [ADDR_W:0] LIMIT = (ADDR_W+1)'(IMEM_DEPTH) << 2;

    logic              redirect;
    logic [ADDR_W-1:0] target;
    logic [ADDR_W:0]   cand;

    always_comb begin
        redirect = jump_i | branch_taken_i;
        target   = jump_i ? jump_target_i : branch_target_i;
        cand     = {1'b0, pc_i} + (ADDR_W+1)'(INSTR_BYTES);
        if (redirect) begin
            cand = {1'b0, ALIGN_CHECK ? target : {target[ADDR_W-1:2], 2'b00}};
        end else if (stall_i) begin
            cand = {1'b0, pc_i};
        end
        misalign_o  = ALIGN_CHECK & redirect & (|target[1:0]);
        oob_o       = (cand >= LIMIT);
        next_addr_o = cand[ADDR_W-1:0];
    end

endmodule

// File: rtl/pc_gen.sv
// Instruction-fetch program counter: BOOT -> RUN -> HALT sequencer with sticky
// fault flags. Define PC_ALIGN_CHECK_EN to halt on misaligned redirect targets.
module pc_gen
    import cpu_pkg::*;
#(
    parameter int                ADDR_W     = 32,
    parameter int                IMEM_DEPTH = 1024,
    parameter logic [ADDR_W-1:0] RESET_VEC  = ADDR_W'(DEFAULT_RESET_VEC)
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              stall,
    input  logic              branch_taken,
    input  logic [ADDR_W-1:0] branch_target,
    input  logic              jump,
    input  logic [ADDR_W-1:0] jump_target,
    output logic [ADDR_W-1:0] pc,
    output logic [ADDR_W-1:0] pc_plus4,
    output logic              imem_en,
    output logic              halted,
    output logic              fault_oob,
    output logic              fault_align
);

    pc_state_t         state_q, state_d;
    logic [ADDR_W-1:0] pc_q, pc_d;
    logic              imem_en_q, imem_en_d;
    logic              halted_q, halted_d;
    logic              fault_oob_q, fault_oob_d;
`ifdef PC_ALIGN_CHECK_EN
    logic              fault_align_q, fault_align_d;
`endif

    logic [ADDR_W-1:0] next_addr;
    logic              oob;
    logic              misalign;

    pc_next_sel #(
        .ADDR_W     (ADDR_W),
        .IMEM_DEPTH (IMEM_DEPTH)
    ) u_next_sel (
        .pc_i            (pc_q),
        .stall_i         (stall),
        .branch_taken_i  (branch_taken),
        .branch_target_i (branch_target),
        .jump_i          (jump),
        .jump_target_i   (jump_target),
        .next_addr_o     (next_addr),
        .oob_o           (oob),
        .misalign_o      (misalign)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= BOOT;
            pc_q        <= RESET_VEC;
            imem_en_q   <= 1'b0;
            halted_q    <= 1'b0;
            fault_oob_q <= 1'b0;
`ifdef PC_ALIGN_CHECK_EN
            fault_align_q <= 1'b0;
`endif
        end else begin
            state_q     <= state_d;
            pc_q        <= pc_d;
            imem_en_q   <= imem_en_d;
            halted_q    <= halted_d;
            fault_oob_q <= fault_oob_d;
`ifdef PC_ALIGN_CHECK_EN
            fault_align_q <= fault_align_d;
`endif
        end
    end

    always_comb begin
        state_d     = state_q;
        pc_d        = pc_q;
        imem_en_d   = imem_en_q;
        halted_d    = halted_q;
        fault_oob_d = fault_oob_q;
`ifdef PC_ALIGN_CHECK_EN
        fault_align_d = fault_align_q;
`endif
        case (state_q)
            BOOT: begin
                // pc already holds RESET_VEC, so the first RUN cycle fetches it.
                state_d   = RUN;
                imem_en_d = 1'b1;
            end
            RUN: begin
                // Alignment is judged first; a faulting fetch leaves pc frozen.
                if (misalign) begin
                    state_d   = HALT;
                    imem_en_d = 1'b0;
                    halted_d  = 1'b1;
`ifdef PC_ALIGN_CHECK_EN
                    fault_align_d = 1'b1;
`endif
                end else if (oob) begin
                    state_d     = HALT;
                    imem_en_d   = 1'b0;
                    halted_d    = 1'b1;
                    fault_oob_d = 1'b1;
                end else begin
                    pc_d = next_addr;
                end
            end
            HALT: begin
            end
            default: begin
                state_d   = HALT;
                imem_en_d = 1'b0;
                halted_d  = 1'b1;
            end
        endcase
    end

    assign pc        = pc_q;
    assign pc_plus4  = pc_q + ADDR_W'(INSTR_BYTES);
    assign imem_en   = imem_en_q;
    assign halted    = halted_q;
    assign fault_oob = fault_oob_q;
`ifdef PC_ALIGN_CHECK_EN
    assign fault_align = fault_align_q;
`else
    assign fault_align = 1'b0;
`endif

endmodule
